irq_ctrl: RTL and testbench

Interrupt controller for the MIPS system bus. Collects interrupt requests from the peripherals behind the bridge (timer, uart, key, switch, ...), latches them as pending, applies a mask and fixed priority, and presents one request line with source id to CP0. It runs an acknowledge / end-of-interrupt handshake with the CPU. It is a bridge slave with a four-word register window.

---
 rtl/irq_ctrl_pkg.sv | 47 ++++
 rtl/irq_ctrl_prio_enc.sv | 32 +++
 rtl/irq_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_irq_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// ============================================================================
// Module      : irq_ctrl_pkg
// Description : Shared definitions for the interrupt controller: register
//               offsets, FSM state encodings and CAUSE bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package irq_ctrl_pkg;

    // Register window offsets (bus address bits [3:2])
    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_EDGE    = 2'd2;
    localparam logic [1:0] REG_CAUSE   = 2'd3;

    // Source id width (supports up to 8 sources)
    localparam int ID_W = 3;

    // CAUSE register bit positions
    localparam int CAUSE_ACTIVE_BIT = 31;
    localparam int CAUSE_INSRV_BIT  = 30;

    // Request/acknowledge state machine encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_INSERVICE = 2'd2
    } irq_state_e;

    // Assemble the CAUSE read word from status flags and the current id
    function automatic logic [31:0] cause_word(
        input logic            active,
        input logic            insrv,
        input logic [ID_W-1:0] id
    );
        logic [31:0] w;
        w                   = '0;
        w[CAUSE_ACTIVE_BIT] = active;
        w[CAUSE_INSRV_BIT]  = insrv;
        w[ID_W-1:0]         = id;
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_ctrl_prio_enc.sv
// ============================================================================
// Module      : irq_prio_enc
// Description : Combinational fixed-priority encoder. Reports whether any
//               request is set and the lowest set index (index 0 wins).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 6
) (
    input  logic [N_SRC-1:0] i_req,
    output logic             o_any,
    output logic [ID_W-1:0]  o_id
);

    // Scan from the top down so the lowest set index is the last to write
    always_comb begin
        o_any = |i_req;
        o_id  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_id = ID_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
// Module      : irq_ctrl
// Description : Interrupt controller for the system bus. Latches device
//               requests as pending (edge or level per source), masks them,
//               picks the lowest-index request and runs an acknowledge /
//               end-of-interrupt handshake with CP0 through a four-word
//               register window (PENDING, MASK, EDGE, CAUSE).
//               Build option: define IRQ_SYNC_EN to pass every irq_in bit
//               through a 2-flop synchroniser (adds 2 cycles of latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [1:0]       addr,
    input  logic             Sel,
    input  logic             We,
    input  logic [31:0]      WD,
    output logic [31:0]      RD,
    output logic             irq_out,
    output logic [ID_W-1:0]  irq_id
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    irq_state_e        r_state;
    irq_state_e        w_state_nxt;
    logic              r_irq_out;
    logic              w_irq_out_nxt;
    logic [ID_W-1:0]   r_irq_id;
    logic [ID_W-1:0]   w_irq_id_nxt;

    logic [N_SRC-1:0]  r_pend;
    logic [N_SRC-1:0]  r_mask;
    logic [N_SRC-1:0]  r_edge;
    logic [N_SRC-1:0]  r_prev;

    logic [N_SRC-1:0]  w_s;
    logic [N_SRC-1:0]  w_rise;
    logic [N_SRC-1:0]  w_w1c;
    logic [N_SRC-1:0]  w_edge_on;
    logic [N_SRC-1:0]  w_id_onehot;
    logic [N_SRC-1:0]  w_ack_clr;
    logic [N_SRC-1:0]  w_pend_nxt;
    logic [N_SRC-1:0]  w_mask_nxt;
    logic [N_SRC-1:0]  w_req;
    logic [N_SRC-1:0]  w_req_nxt;
    logic              w_req_id_nxt;
    logic              w_any;
    logic [ID_W-1:0]   w_win;

    logic              w_wr;
    logic              w_wr_pend;
    logic              w_wr_mask;
    logic              w_wr_edge;
    logic              w_ack;
    logic              w_eoi;
    logic [31:0]       w_rd;
    logic              w_unused_wd;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] r_sync1;
    logic [N_SRC-1:0] r_sync2;

    // Two-flop synchroniser for asynchronous device lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = irq_in;
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    assign w_wr      = Sel & We;
    assign w_wr_pend = w_wr & (addr == REG_PENDING);
    assign w_wr_mask = w_wr & (addr == REG_MASK);
    assign w_wr_edge = w_wr & (addr == REG_EDGE);
    assign w_eoi     = w_wr & (addr == REG_CAUSE);
    // Only a CAUSE read while a request is presented counts as acknowledge
    assign w_ack     = Sel & ~We & (addr == REG_CAUSE) & (r_state == ST_ACTIVE);

    // Write data bits above the source count are deliberately discarded
    assign w_unused_wd = ^WD;

    // ------------------------------------------------------------------
    // Pending / mask next-state
    // ------------------------------------------------------------------
    assign w_rise     = w_s & ~r_prev;
    assign w_w1c      = w_wr_pend ? WD[N_SRC-1:0] : '0;
    assign w_edge_on  = w_wr_edge ? (WD[N_SRC-1:0] & ~r_edge) : '0;
    assign w_mask_nxt = w_wr_mask ? WD[N_SRC-1:0] : r_mask;

    // Decode the latched id into a per-source select for acknowledge clearing
    always_comb begin
        w_id_onehot = '0;
        w_ack_clr   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_id_onehot[i] = (r_irq_id == ID_W'(i));
            w_ack_clr[i]   = w_ack & r_edge[i] & w_id_onehot[i];
        end
    end

    // Edge bits hold until cleared (a new edge beats any clear); level bits track the input
    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_edge[i]) begin
                w_pend_nxt[i] = (r_pend[i] & ~w_w1c[i] & ~w_ack_clr[i]) | w_rise[i];
            end else begin
                w_pend_nxt[i] = w_s[i];
            end
            if (w_edge_on[i]) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
    end

    // Source registers: pending, mask, mode and previous input sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_mask <= '0;
            r_edge <= '0;
            r_prev <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_mask <= w_mask_nxt;
            r_prev <= w_s;
            if (w_wr_edge) begin
                r_edge <= WD[N_SRC-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_req        = r_pend & r_mask;
    // Looking at next-cycle request lets a mask-off/W1C/release drop irq_out in one cycle
    assign w_req_nxt    = w_pend_nxt & w_mask_nxt;
    assign w_req_id_nxt = |(w_req_nxt & w_id_onehot);

    irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .i_req (w_req),
        .o_any (w_any),
        .o_id  (w_win)
    );

    // ------------------------------------------------------------------
    // Request / acknowledge state machine
    // ------------------------------------------------------------------

    // State register together with the registered CP0 outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_irq_out <= 1'b0;
            r_irq_id  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_irq_out <= w_irq_out_nxt;
            r_irq_id  <= w_irq_id_nxt;
        end
    end

    // Next-state: acknowledge beats a simultaneous request drop; no preemption
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_ack) begin
                    w_state_nxt = ST_INSERVICE;
                end else if (!w_req_id_nxt) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_INSERVICE: begin
                if (w_eoi) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs: request only while ACTIVE; id latched on entry to ACTIVE and held otherwise
    always_comb begin
        w_irq_out_nxt = (w_state_nxt == ST_ACTIVE);
        w_irq_id_nxt  = r_irq_id;
        if ((r_state == ST_IDLE) && w_any) begin
            w_irq_id_nxt = w_win;
        end
    end

    // ------------------------------------------------------------------
    // Read mux (combinational from addr)
    // ------------------------------------------------------------------
    always_comb begin
        w_rd = '0;
        case (addr)
            REG_PENDING: w_rd = 32'(r_pend);
            REG_MASK:    w_rd = 32'(r_mask);
            REG_EDGE:    w_rd = 32'(r_edge);
            REG_CAUSE:   w_rd = cause_word(r_state == ST_ACTIVE,
                                           r_state == ST_INSERVICE,
                                           r_irq_id);
            default:     w_rd = '0;
        endcase
    end

    assign RD      = w_rd;
    assign irq_out = r_irq_out;
    assign irq_id  = r_irq_id;

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Self-checking bench for irq_ctrl. Stimulus pushes expected
//               observations into a queue; a monitor pops and compares them
//               against the DUT when the stimulus flags a sample point.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl;

    localparam int N_SRC = 6;
`ifdef IRQ_SYNC_EN
    localparam int LAT  = 4;
    localparam logic COLL = 1'b0;
`else
    localparam int LAT  = 2;
    localparam logic COLL = 1'b1;
`endif

    localparam int K_RD  = 0;
    localparam int K_OUT = 1;
    localparam int K_ID  = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_SRC-1:0] irq_in;
    logic [1:0]       addr;
    logic             Sel;
    logic             We;
    logic [31:0]      WD;
    logic [31:0]      RD;
    logic             irq_out;
    logic [2:0]       irq_id;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    logic mon_req = 1'b0;
    int   n_vec   = 0;
    int   n_miss  = 0;

    irq_ctrl #(.N_SRC(N_SRC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .irq_in  (irq_in),
        .addr    (addr),
        .Sel     (Sel),
        .We      (We),
        .WD      (WD),
        .RD      (RD),
        .irq_out (irq_out),
        .irq_id  (irq_id)
    );

    always #5 clk = ~clk;

    // Monitor: at each flagged sample point, drain and compare all expectations
    initial begin
        forever begin
            @(negedge clk);
            if (mon_req) begin
                while (q.size() > 0) begin
                    exp_t e;
                    logic [31:0] act;
                    e = q.pop_front();
                    case (e.kind)
                        K_RD:    act = RD;
                        K_OUT:   act = {31'b0, irq_out};
                        default: act = {29'b0, irq_id};
                    endcase
                    n_vec++;
                    if (act !== e.exp) begin
                        n_miss++;
                        $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int kind, input string name, input logic [31:0] v);
        exp_t e;
        e.kind = kind;
        e.name = name;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic sample();
        mon_req = 1'b1;
        @(negedge clk);
        #1;
        mon_req = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Sel  = 1'b1;
        We   = 1'b1;
        addr = a;
        WD   = d;
        tick();
        Sel  = 1'b0;
        We   = 1'b0;
        WD   = '0;
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n  = 1'b0;
        irq_in = 6'h3F;
        addr   = 2'd0;
        Sel    = 1'b0;
        We     = 1'b0;
        WD     = '0;
        tick();
        tick();
        expect_val(K_OUT, "rst_irq_out", 32'd0);
        expect_val(K_ID,  "rst_irq_id",  32'd0);
        expect_val(K_RD,  "rst_pending", 32'd0);
        sample();
        for (int a = 1; a < 4; a++) begin
            addr = 2'(a);
            expect_val(K_RD, $sformatf("rst_reg%0d", a), 32'd0);
            sample();
        end
        irq_in = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- edge source 0 ----------------
        wr(2'd2, 32'h1);
        wr(2'd1, 32'h1);
        irq_in = 6'h01;
        tick();
        irq_in = '0;
        expect_val(K_OUT, "edge_t1_irq_out", 32'd0);
        sample();
        tick();
        Sel = 1'b1; We = 1'b0; addr = 2'd3;
        expect_val(K_OUT, "edge_t2_irq_out", 32'd1);
        expect_val(K_ID,  "edge_t2_irq_id",  32'd0);
        expect_val(K_RD,  "edge_ack_cause",  32'h8000_0000);
        sample();
        tick();
        Sel = 1'b0;
        expect_val(K_OUT, "edge_insrv_irq_out", 32'd0);
        expect_val(K_RD,  "edge_insrv_cause",   32'h4000_0000);
        sample();
        addr = 2'd0;
        expect_val(K_RD, "edge_pend_cleared", 32'd0);
        sample();
        wr(2'd3, 32'h0);
        addr = 2'd3;
        expect_val(K_RD, "edge_eoi_cause", 32'd0);
        sample();
        tick();
        expect_val(K_OUT, "edge_no_reassert", 32'd0);
        sample();

        // ---------------- priority, no preemption ----------------
        wr(2'd2, 32'h0);
        wr(2'd1, 32'h3F);
        irq_in = 6'h08;
        tick();
        tick();
        expect_val(K_OUT, "prio_irq_out", 32'd1);
        expect_val(K_ID,  "prio_id3",     32'd3);
        sample();
        irq_in = 6'h0A;
        tick();
        tick();
        Sel = 1'b1; We = 1'b0; addr = 2'd3;
        expect_val(K_ID, "prio_no_preempt", 32'd3);
        expect_val(K_RD, "prio_ack_cause",  32'h8000_0003);
        sample();
        tick();
        Sel = 1'b0; addr = 2'd0;
        expect_val(K_OUT, "prio_insrv_irq_out", 32'd0);
        expect_val(K_RD,  "prio_level_pend",    32'h0000_000A);
        sample();
        wr(2'd3, 32'h0);
        expect_val(K_OUT, "prio_eoi_t1", 32'd0);
        sample();
        tick();
        expect_val(K_OUT, "prio_eoi_t2_irq_out", 32'd1);
        expect_val(K_ID,  "prio_next_id1",       32'd1);
        sample();
        irq_in = '0;
        tick();
        tick();
        addr = 2'd3;
        expect_val(K_OUT, "prio_release_irq_out", 32'd0);
        expect_val(K_RD,  "prio_release_cause",   32'h0000_0001);
        sample();

        // ---------------- mask while ACTIVE ----------------
        irq_in = 6'h04;
        tick();
        tick();
        expect_val(K_OUT, "mask_active_irq_out", 32'd1);
        expect_val(K_ID,  "mask_active_id2",     32'd2);
        sample();
        wr(2'd1, 32'h0);
        addr = 2'd3;
        expect_val(K_OUT, "mask_off_irq_out", 32'd0);
        expect_val(K_RD,  "mask_off_cause",   32'h0000_0002);
        sample();
        addr = 2'd0;
        expect_val(K_RD, "mask_off_pending", 32'h0000_0004);
        sample();
        irq_in = '0;
        tick();
        tick();

        // ---------------- register widths and W1C collision ----------------
        wr(2'd1, 32'hFFFF_FFFF);
        addr = 2'd1;
        expect_val(K_RD, "mask_upper_bits", 32'h0000_003F);
        sample();
        wr(2'd1, 32'h0);
        wr(2'd2, 32'h10);
        addr = 2'd2;
        expect_val(K_RD, "edge_readback", 32'h0000_0010);
        sample();
        irq_in = 6'h10;
        wr(2'd0, 32'h10);
        addr = 2'd0;
        expect_val(K_RD, "collision_set_wins", 32'h0000_0010);
        sample();
        wr(2'd0, 32'h10);
        addr = 2'd0;
        expect_val(K_RD, "w1c_clears", 32'd0);
        sample();
        irq_in = '0;
        tick();

        // ---------------- edge-to-request latency ----------------
        wr(2'd2, 32'h1);
        wr(2'd1, 32'h1);
        irq_in = 6'h01;
        for (int k = 0; k <= LAT; k++) begin
            expect_val(K_OUT, $sformatf("latency_t%0d", k), (k >= LAT) ? 32'd1 : 32'd0);
            sample();
            tick();
            irq_in = '0;
        end

        // ---------------- acknowledge with simultaneous new edge ----------------
        Sel = 1'b1; We = 1'b0; addr = 2'd3;
        irq_in = {5'b0, COLL};
        expect_val(K_RD, "lat_ack_cause", 32'h8000_0000);
        sample();
        tick();
        Sel = 1'b0; irq_in = '0; addr = 2'd0;
        expect_val(K_OUT, "ackedge_irq_out",  32'd0);
        expect_val(K_RD,  "ackedge_pending",  32'(COLL));
        sample();
        wr(2'd3, 32'h0);
        tick();
        expect_val(K_OUT, "ackedge_reassert", 32'(COLL));
        sample();

        // ---------------- asynchronous reset mid-operation ----------------
        rst_n = 1'b0;
        #2;
        addr = 2'd1;
        expect_val(K_OUT, "async_rst_irq_out", 32'd0);
        expect_val(K_ID,  "async_rst_irq_id",  32'd0);
        expect_val(K_RD,  "async_rst_mask",    32'd0);
        sample();
        tick();

        if (q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL queue_drain: got %0d left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
